// File: rtl/inst_fetch_frontend_pkg.sv
// Shared types and constants for the instruction-fetch front end:
// defaults, FSM state encodings and the fill request/response records.
package inst_fetch_frontend_pkg;
    localparam int          ICACHE_IDX_BITS_DEF = 6;
    localparam logic [31:0] RESET_PC_DEF        = 32'h0;
    localparam int          MEM_BYTES           = 4;
    localparam int          CNT_W               = $clog2(MEM_BYTES + 1);

    typedef enum logic {SEQ_FETCH, SEQ_WAIT} seq_state_t;
    typedef enum logic {MC_IDLE, MC_BUSY}    mc_state_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] addr;
    } fill_req_t;

    typedef struct packed {
        logic        done;
        logic [31:0] word;
    } fill_rsp_t;
endpackage

// File: rtl/inst_fetch_frontend_byte_mem_reader.sv
// Byte-serial RAM reader: walks four byte addresses and assembles a
// little-endian word, pulsing rsp.done for one cycle when it is complete.
module inst_fetch_frontend_byte_mem_reader
    import inst_fetch_frontend_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  fill_req_t   req,
    input  logic [7:0]  mem_din,
    output logic [31:0] mem_a,
    output logic        busy,
    output fill_rsp_t   rsp
);
    mc_state_t        state;
    logic [31:0]      addr;
    logic [CNT_W-1:0] cnt;
    logic [23:0]      acc;

    assign busy = (state == MC_BUSY);

    // RAM data lags its address by one cycle, so while frozen we keep
    // presenting the byte that the next capture will consume.
    always_comb begin
        mem_a = '0;
        if (state == MC_BUSY) begin
            if (!rdy && cnt != '0)
                mem_a = addr + 32'(cnt) - 32'd1;
            else if (cnt < CNT_W'(MEM_BYTES))
                mem_a = addr + 32'(cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MC_IDLE;
            addr  <= '0;
            cnt   <= '0;
            acc   <= '0;
            rsp   <= '0;
        end else if (rdy) begin
            rsp.done <= 1'b0;
            case (state)
                MC_IDLE: begin
                    if (req.vld) begin
                        state <= MC_BUSY;
                        addr  <= req.addr;
                        cnt   <= '0;
                    end
                end
                MC_BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    case (cnt)
                        CNT_W'(1): acc[7:0]   <= mem_din;
                        CNT_W'(2): acc[15:8]  <= mem_din;
                        CNT_W'(3): acc[23:16] <= mem_din;
                        CNT_W'(4): begin
                            rsp.word <= {mem_din, acc};
                            rsp.done <= 1'b1;
                            state    <= MC_IDLE;
                        end
                        default: ;
                    endcase
                end
                default: state <= MC_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/inst_fetch_frontend.sv
// RV32I fetch front end: PC sequencer plus direct-mapped one-word-per-line
// I-cache, refilled through the byte-serial memory reader.
module inst_fetch_frontend
    import inst_fetch_frontend_pkg::*;
#(
    parameter int          ICACHE_IDX_BITS = ICACHE_IDX_BITS_DEF,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        jump_flag,
    input  logic [31:0] target_pc,
    input  logic        dec_stall,
    output logic        inst_send_enable,
    output logic [31:0] inst_to_dec,
    output logic [31:0] pc_to_dec
);
    localparam int LINES = 1 << ICACHE_IDX_BITS;
    localparam int TAG_W = 32 - ICACHE_IDX_BITS - 2;

    seq_state_t                 state;
    logic [31:0]                pc;
    logic                       orphan;
    logic [LINES-1:0]           valid;
    logic [31:0]                data_arr [LINES];
    logic [TAG_W-1:0]           tag_arr  [LINES];
    logic [ICACHE_IDX_BITS-1:0] idx, fill_idx;
    logic [TAG_W-1:0]           tag, fill_tag;
    logic                       hit, lookup, mc_busy;
    fill_req_t                  req;
    fill_rsp_t                  rsp;
    logic                       unused_io;

    assign mem_dout  = '0;
    assign mem_wr    = 1'b0;
    assign unused_io = io_buffer_full;

    assign idx    = pc[ICACHE_IDX_BITS+1:2];
    assign tag    = pc[31:ICACHE_IDX_BITS+2];
    assign hit    = valid[idx] && (tag_arr[idx] == tag);
    assign lookup = (state == SEQ_FETCH) && !jump_flag && !dec_stall;

    // A miss is only launched once any orphaned fill has drained.
    assign req.vld  = lookup && !hit && !mc_busy;
    assign req.addr = pc;

    inst_fetch_frontend_byte_mem_reader u_reader (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .req    (req),
        .mem_din(mem_din),
        .mem_a  (mem_a),
        .busy   (mc_busy),
        .rsp    (rsp)
    );

    always_ff @(posedge clk) begin
        if (rdy && rsp.done) begin
            data_arr[fill_idx] <= rsp.word;
            tag_arr[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= SEQ_FETCH;
            pc               <= RESET_PC;
            orphan           <= 1'b0;
            valid            <= '0;
            fill_idx         <= '0;
            fill_tag         <= '0;
            inst_send_enable <= 1'b0;
            inst_to_dec      <= '0;
            pc_to_dec        <= '0;
        end else if (rdy) begin
            inst_send_enable <= 1'b0;
            if (rsp.done) begin
                valid[fill_idx] <= 1'b1;
                orphan          <= 1'b0;
            end
            if (req.vld) begin
                fill_idx <= idx;
                fill_tag <= tag;
            end
            if (jump_flag) begin
                // An in-flight fill still lands in the cache but is never forwarded.
                pc     <= target_pc;
                state  <= SEQ_FETCH;
                orphan <= mc_busy;
            end else begin
                case (state)
                    SEQ_FETCH: begin
                        if (lookup && hit) begin
                            inst_send_enable <= 1'b1;
                            inst_to_dec      <= data_arr[idx];
                            pc_to_dec        <= pc;
                            pc               <= pc + 32'd4;
                        end else if (req.vld) begin
                            state <= SEQ_WAIT;
                        end
                    end
                    SEQ_WAIT: begin
                        if (rsp.done && !orphan) begin
                            inst_send_enable <= 1'b1;
                            inst_to_dec      <= rsp.word;
                            pc_to_dec        <= pc;
                            pc               <= pc + 32'd4;
                            state            <= SEQ_FETCH;
                        end
                    end
                    default: state <= SEQ_FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_frontend.sv
// Scenario bench for inst_fetch_frontend: byte RAM model, expected-delivery
// queue popped on every inst_send_enable, plus per-scenario latency checks.
module tb_inst_fetch_frontend;
    logic        clk = 1'b0;
    logic        rst, rdy, jump_flag, dec_stall, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a, target_pc, inst_to_dec, pc_to_dec;
    logic        mem_wr, inst_send_enable;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ram [1024];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_din <= ram[mem_a[9:0]];

    inst_fetch_frontend #(.ICACHE_IDX_BITS(6), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
        .jump_flag(jump_flag), .target_pc(target_pc), .dec_stall(dec_stall),
        .inst_send_enable(inst_send_enable), .inst_to_dec(inst_to_dec),
        .pc_to_dec(pc_to_dec)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] b0, b1, b2, b3;
        b0 = a; b1 = a + 32'd1; b2 = a + 32'd2; b3 = a + 32'd3;
        return {ram[b3[9:0]], ram[b2[9:0]], ram[b1[9:0]], ram[b0[9:0]]};
    endfunction

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        e.inst = word_at(pc);
        exp_q.push_back(e);
    endtask

    // Advance one clock, sample just after the edge, and score any delivery.
    task automatic step();
        exp_t e;
        @(posedge clk); #1;
        if (inst_send_enable === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL delivery_unexpected got pc=%h inst=%h want none", pc_to_dec, inst_to_dec);
            end else begin
                e = exp_q.pop_front();
                if (pc_to_dec !== e.pc || inst_to_dec !== e.inst) begin
                    n_fail++;
                    $display("FAIL delivery got pc=%h inst=%h want pc=%h inst=%h",
                             pc_to_dec, inst_to_dec, e.pc, e.inst);
                end
            end
        end
    endtask

    task automatic wait_deliver(input int max, input bit stall_after, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (inst_send_enable !== 1'b1 && n < max);
        if (inst_send_enable !== 1'b1) n = -1;
        if (stall_after) dec_stall = 1'b1;
    endtask

    task automatic do_jump(input logic [31:0] t);
        jump_flag = 1'b1;
        target_pc = t;
        dec_stall = 1'b0;
        step();
        jump_flag = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; jump_flag = 1'b0; dec_stall = 1'b0;
        io_buffer_full = 1'b0; target_pc = '0;
        repeat (3) step();
        n_checks++; if (inst_send_enable !== 1'b0) begin n_fail++; $display("FAIL rst_send got %b want 0", inst_send_enable); end
        n_checks++; if (inst_to_dec !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h want 0", inst_to_dec); end
        n_checks++; if (pc_to_dec !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", pc_to_dec); end
        n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL rst_mem_a got %h want 0", mem_a); end
        n_checks++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL rst_mem_dout got %h want 0", mem_dout); end
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wr got %b want 0", mem_wr); end
    endtask

    task automatic test_cold_start();
        int n;
        push(32'h0); push(32'h4);
        rst = 1'b1;
        wait_deliver(20, 1'b0, n);
        n_checks++; if (n !== 7) begin n_fail++; $display("FAIL cold_latency got %0d want 7", n); end
        n_checks++; if (inst_to_dec !== 32'h00100513) begin n_fail++; $display("FAIL cold_inst0 got %h want 00100513", inst_to_dec); end
        wait_deliver(20, 1'b1, n);
        n_checks++; if (n !== 7) begin n_fail++; $display("FAIL second_latency got %0d want 7", n); end
        n_checks++; if (inst_to_dec !== 32'h00200593 || pc_to_dec !== 32'h4) begin
            n_fail++; $display("FAIL cold_inst1 got pc=%h inst=%h want pc=4 inst=00200593", pc_to_dec, inst_to_dec); end
    endtask

    task automatic test_dec_stall();
        int n;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (inst_send_enable !== 1'b0 || mem_a !== 32'h0) begin
                n_fail++; $display("FAIL stall_idle cycle %0d got send=%b mem_a=%h want 0/0", i, inst_send_enable, mem_a);
            end
        end
        push(32'h8);
        dec_stall = 1'b0;
        step(); step();
        dec_stall = 1'b1;
        wait_deliver(10, 1'b1, n);
        n_checks++; if (n + 2 !== 7) begin n_fail++; $display("FAIL stall_resume_latency got %0d want 7", n + 2); end
        repeat (3) step();
        n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL stall_no_request got mem_a=%h want 0", mem_a); end
    endtask

    task automatic test_loop();
        int c = 0, d0 = -1, d1 = -1, n;
        bit mem_act = 1'b0;
        push(32'h0); push(32'h4);
        do_jump(32'h0);
        n_checks++; if (inst_send_enable !== 1'b0) begin n_fail++; $display("FAIL jump_send got %b want 0", inst_send_enable); end
        while (d1 < 0 && c < 6) begin
            step(); c++;
            if (mem_a !== 32'h0) mem_act = 1'b1;
            if (inst_send_enable === 1'b1) begin
                if (d0 < 0) d0 = c; else d1 = c;
            end
        end
        n_checks++; if (d0 !== 1 || d1 !== 2) begin n_fail++; $display("FAIL loop_timing got %0d,%0d want 1,2", d0, d1); end
        n_checks++; if (mem_act) begin n_fail++; $display("FAIL loop_mem_activity got active want idle"); end
        // The pc 8 lookup in this cycle would hit; the jump must win.
        push(32'h0);
        do_jump(32'h0);
        n_checks++; if (inst_send_enable !== 1'b0) begin n_fail++; $display("FAIL jump_priority got send=%b want 0", inst_send_enable); end
        wait_deliver(4, 1'b1, n);
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL rejump_latency got %0d want 1", n); end
    endtask

    task automatic test_rdy_hold();
        int c = 0, n;
        push(32'h20);
        do_jump(32'h20);
        while (mem_a !== 32'h22 && c < 10) begin step(); c++; end
        n_checks++; if (c !== 3) begin n_fail++; $display("FAIL rdy_reach_cnt2 got %0d want 3", c); end
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (mem_a !== 32'h21) begin n_fail++; $display("FAIL rdy_hold_mem_a cycle %0d got %h want 21", i, mem_a); end
            if (i < 2) step();
        end
        step();
        rdy = 1'b1;
        wait_deliver(12, 1'b1, n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL rdy_resume_latency got %0d want 4", n); end
    endtask

    task automatic test_jump_during_fill();
        int c = 0, n;
        bit idle_seen = 1'b0, got_a = 1'b0, delivered = 1'b0;
        logic [31:0] first_a = '0;
        do_jump(32'h60);
        while (mem_a !== 32'h62 && c < 10) begin step(); c++; end
        n_checks++; if (c !== 3) begin n_fail++; $display("FAIL jfill_reach_cnt2 got %0d want 3", c); end
        push(32'h40);
        do_jump(32'h40);
        n_checks++; if (inst_send_enable !== 1'b0) begin n_fail++; $display("FAIL jfill_send got %b want 0", inst_send_enable); end
        for (int i = 0; i < 20 && !delivered; i++) begin
            step();
            if (mem_a === 32'h0) idle_seen = 1'b1;
            else if (idle_seen && !got_a) begin got_a = 1'b1; first_a = mem_a; end
            if (inst_send_enable === 1'b1) begin delivered = 1'b1; dec_stall = 1'b1; end
        end
        n_checks++; if (!got_a || first_a !== 32'h40) begin n_fail++; $display("FAIL jfill_next_addr got %h want 40", first_a); end
        n_checks++; if (!delivered) begin n_fail++; $display("FAIL jfill_delivery got none want pc 40"); end
        push(32'h60);
        do_jump(32'h60);
        wait_deliver(10, 1'b1, n);
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL orphan_line_hit got %0d want 1", n); end
    endtask

    task automatic test_conflict();
        int n;
        push(32'h0);
        do_jump(32'h0);
        wait_deliver(10, 1'b1, n);
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL conflict_first_hit got %0d want 1", n); end
        push(32'h100);
        do_jump(32'h100);
        wait_deliver(12, 1'b1, n);
        n_checks++; if (n !== 7) begin n_fail++; $display("FAIL conflict_miss got %0d want 7", n); end
        push(32'h0);
        do_jump(32'h0);
        wait_deliver(12, 1'b1, n);
        n_checks++; if (n !== 7) begin n_fail++; $display("FAIL conflict_refetch got %0d want 7", n); end
    endtask

    task automatic test_pc_wrap();
        int n;
        push(32'hFFFFFFFC); push(32'h0);
        do_jump(32'hFFFFFFFC);
        wait_deliver(12, 1'b0, n);
        n_checks++; if (n !== 7) begin n_fail++; $display("FAIL wrap_miss got %0d want 7", n); end
        wait_deliver(4, 1'b1, n);
        n_checks++; if (n !== 1) begin n_fail++; $display("FAIL wrap_next_hit got %0d want 1", n); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 37 + 11);
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
        ram[4] = 8'h93; ram[5] = 8'h05; ram[6] = 8'h20; ram[7] = 8'h00;
        test_reset();
        test_cold_start();
        test_dec_stall();
        test_loop();
        test_rdy_hold();
        test_jump_during_fill();
        test_conflict();
        test_pc_wrap();
        repeat (4) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL pending_deliveries got %0d want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
